// File: rtl/apb_cmd_master_if.sv
// Bundle of the command stream, the response stream and the APB bus
// for apb_cmd_master. The master modport is the requester's view;
// the slave modport is the view of whatever sits on the other side
// (command source, response sink and APB completer together).
interface apb_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSEL   = 1
);
    localparam int STRB_W = DATA_W / 8;

    // command stream
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_write;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strb;
    logic [2:0]        cmd_prot;
    logic [NSEL-1:0]   cmd_sel;

    // response stream
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    // APB bus
    logic [ADDR_W-1:0] PADDR;
    logic [NSEL-1:0]   PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [STRB_W-1:0] PSTRB;
    logic [2:0]        PPROT;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb, cmd_prot, cmd_sel,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb, cmd_prot, cmd_sel,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB3/APB4 requester: turns a valid/ready command stream into APB
// SETUP/ACCESS phases and returns each completion (read data, slave
// error, timeout, illegal select) on a valid/ready response stream.
module apb_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NSEL    = 1,
    parameter int TIMEOUT = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic apb4_en,
    apb_cmd_master_if.master bus
);
    localparam int STRB_W = DATA_W / 8;
    // keep the counter at least 1 bit wide when the timeout is disabled
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t            state;
    state_t            state_n;

    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [STRB_W-1:0] pstrb_q;
    logic [2:0]        pprot_q;
    logic [NSEL-1:0]   psel_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              tmo_q;

    logic [NSEL-1:0]   sel_m1;
    logic              sel_onehot;
    logic              timeout_hit;

    // one-hot test: non-zero and clearing the lowest set bit leaves nothing
    assign sel_m1      = bus.cmd_sel - NSEL'(1);
    assign sel_onehot  = (|bus.cmd_sel) && ~|(bus.cmd_sel & sel_m1);
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT));

    // state register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_n;
    end

    // next-state: PREADY wins over a timeout reached in the same cycle
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.cmd_valid) state_n = sel_onehot ? SETUP : RESP;
            SETUP:   state_n = ACCESS;
            ACCESS:  if (bus.PREADY || timeout_hit) state_n = RESP;
            RESP:    if (bus.rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // command capture, wait counting and response capture; bus-side
    // registers load only for legal selects so an idle bus never toggles
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            pprot_q  <= '0;
            psel_q   <= '0;
            wait_cnt <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        if (sel_onehot) begin
                            paddr_q  <= bus.cmd_addr;
                            pwrite_q <= bus.cmd_write;
                            pwdata_q <= bus.cmd_wdata;
                            pstrb_q  <= bus.cmd_write ? (apb4_en ? bus.cmd_strb : '1) : '0;
                            pprot_q  <= apb4_en ? bus.cmd_prot : 3'b000;
                            psel_q   <= bus.cmd_sel;
                            wait_cnt <= '0;
                        end else begin
                            rdata_q  <= '0;
                            err_q    <= 1'b1;
                            tmo_q    <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (bus.PREADY) begin
                        rdata_q  <= pwrite_q ? '0 : bus.PRDATA;
                        err_q    <= bus.PSLVERR;
                        tmo_q    <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q  <= '0;
                        err_q    <= 1'b1;
                        tmo_q    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready   = (state == IDLE) && PRESETn;
    assign bus.rsp_valid   = (state == RESP);
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_err     = err_q;
    assign bus.rsp_timeout = tmo_q;

    assign bus.PSEL    = ((state == SETUP) || (state == ACCESS)) ? psel_q : '0;
    assign bus.PENABLE = (state == ACCESS);
    assign bus.PADDR   = paddr_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.PSTRB   = pstrb_q;
    assign bus.PPROT   = pprot_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed cases plus randomized commands
// against a transaction-level reference (expected response per command,
// expected bus transfer per legal command), a reactive APB completer
// and a response monitor popping a scoreboard queue.
module tb_apb_cmd_master;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NS  = 2;
    localparam int TMO = 4;
    localparam int SW  = DW / 8;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;
    logic apb4_en = 1'b1;

    apb_cmd_master_if #(.ADDR_W(AW), .DATA_W(DW), .NSEL(NS)) bus ();

    apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .NSEL(NS), .TIMEOUT(TMO)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .apb4_en (apb4_en),
        .bus     (bus)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
    } rsp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          write;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [2:0]    prot;
        logic [NS-1:0] sel;
        int unsigned   waits;
        logic          err;
        logic [DW-1:0] rdata;
    } xfer_t;

    rsp_t  exp_q[$];
    xfer_t bus_q[$];

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int unsigned last_acc = 0;
    int unsigned prev_acc = 0;
    int          rdy_mode = 0;     // 0 random, 1 always ready, 2 held low
    bit          completer_off = 1'b0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // response sink
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge PCLK); #1;
            case (rdy_mode)
                1:       bus.rsp_ready = 1'b1;
                2:       bus.rsp_ready = 1'b0;
                default: bus.rsp_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // APB completer: checks each transfer against the expected one and
    // answers after the chosen number of wait states
    initial begin
        xfer_t       x;
        int unsigned k;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = '0;
        forever begin
            @(posedge PCLK); #1;
            if (!completer_off && PRESETn && (bus.PSEL != 0) && !bus.PENABLE) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_setup", 64'(bus.PSEL), 64'(0));
                end else begin
                    x = bus_q.pop_front();
                    chk("setup_psel",   64'(bus.PSEL),   64'(x.sel));
                    chk("setup_paddr",  64'(bus.PADDR),  64'(x.addr));
                    chk("setup_pwrite", 64'(bus.PWRITE), 64'(x.write));
                    if (x.write) chk("setup_pwdata", 64'(bus.PWDATA), 64'(x.wdata));
                    chk("setup_pstrb",  64'(bus.PSTRB),  64'(x.strb));
                    chk("setup_pprot",  64'(bus.PPROT),  64'(x.prot));
                    bus.PREADY  = 1'($urandom);
                    bus.PSLVERR = 1'($urandom);
                    bus.PRDATA  = $urandom;
                    k = 0;
                    forever begin
                        @(posedge PCLK); #1;
                        chk("access_penable", 64'(bus.PENABLE), 64'(1));
                        chk("access_psel",    64'(bus.PSEL),    64'(x.sel));
                        chk("access_paddr",   64'(bus.PADDR),   64'(x.addr));
                        chk("access_pstrb",   64'(bus.PSTRB),   64'(x.strb));
                        if (k == x.waits) begin
                            bus.PREADY  = 1'b1;
                            bus.PSLVERR = x.err;
                            bus.PRDATA  = x.rdata;
                        end else begin
                            bus.PREADY  = 1'b0;
                            bus.PSLVERR = 1'($urandom);
                            bus.PRDATA  = $urandom;
                        end
                        if (k == x.waits || k == TMO) break;
                        k++;
                    end
                    @(posedge PCLK); #1;
                    chk("idle_psel",       64'(bus.PSEL),    64'(0));
                    chk("idle_penable",    64'(bus.PENABLE), 64'(0));
                    chk("idle_paddr_hold", 64'(bus.PADDR),   64'(x.addr));
                    bus.PREADY  = 1'($urandom);
                    bus.PSLVERR = 1'($urandom);
                    bus.PRDATA  = $urandom;
                end
            end
        end
    end

    // response monitor
    initial begin
        rsp_t          e;
        bit            held;
        logic [DW-1:0] h_rdata;
        logic          h_err;
        logic          h_tmo;
        held = 1'b0;
        forever begin
            @(negedge PCLK);
            if (PRESETn && bus.rsp_valid) begin
                chk("rsp_cmd_ready_low", 64'(bus.cmd_ready), 64'(0));
                if (held) begin
                    chk("rsp_stable_rdata", 64'(bus.rsp_rdata),   64'(h_rdata));
                    chk("rsp_stable_err",   64'(bus.rsp_err),     64'(h_err));
                    chk("rsp_stable_tmo",   64'(bus.rsp_timeout), 64'(h_tmo));
                end
                if (bus.rsp_ready) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 64'(bus.rsp_valid), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_rdata",   64'(bus.rsp_rdata),   64'(e.rdata));
                        chk("rsp_err",     64'(bus.rsp_err),     64'(e.err));
                        chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(e.tmo));
                    end
                end else begin
                    held    = 1'b1;
                    h_rdata = bus.rsp_rdata;
                    h_err   = bus.rsp_err;
                    h_tmo   = bus.rsp_timeout;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    // issue one command, wait for acceptance, record expectations
    task automatic send(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input logic [2:0] p, input logic [NS-1:0] sel,
                        input int unsigned waits, input logic e, input logic [DW-1:0] rd,
                        input bit expect_rsp);
        xfer_t x;
        rsp_t  r;
        bit    acc;
        bit    legal;
        int    n;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_write = w;
        bus.cmd_wdata = d;
        bus.cmd_strb  = s;
        bus.cmd_prot  = p;
        bus.cmd_sel   = sel;
        acc = 1'b0;
        n   = 0;
        while (!acc) begin
            @(negedge PCLK);
            acc = bus.cmd_ready;
            @(posedge PCLK);
            if (!acc) begin
                n++;
                if (n > 100) begin
                    chk("accept_timeout", 64'(n), 64'(0));
                    bus.cmd_valid = 1'b0;
                    #1;
                    return;
                end
            end
        end
        prev_acc = last_acc;
        last_acc = cyc;
        legal = (sel == 2'b01) || (sel == 2'b10);
        if (legal && expect_rsp) begin
            x.addr  = a;
            x.write = w;
            x.wdata = d;
            x.strb  = w ? (apb4_en ? s : 4'b1111) : 4'b0000;
            x.prot  = apb4_en ? p : 3'b000;
            x.sel   = sel;
            x.waits = waits;
            x.err   = e;
            x.rdata = rd;
            bus_q.push_back(x);
        end
        if (!legal) begin
            r.rdata = '0; r.err = 1'b1; r.tmo = 1'b0;
        end else if (waits > TMO) begin
            r.rdata = '0; r.err = 1'b1; r.tmo = 1'b1;
        end else begin
            r.rdata = w ? '0 : rd; r.err = e; r.tmo = 1'b0;
        end
        if (expect_rsp) exp_q.push_back(r);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        bus.cmd_valid = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || bus_q.size() != 0) && n < 500) begin
            @(negedge PCLK);
            n++;
        end
        if (n >= 500) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
        repeat (2) @(posedge PCLK);
        #1;
    endtask

    initial begin
        logic [NS-1:0] s;
        int unsigned   r;
        int unsigned   wt;
        int            n;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_write = 1'b0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.cmd_prot  = '0;
        bus.cmd_sel   = '0;

        // reset state
        repeat (3) @(negedge PCLK);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
        chk("rst_psel",      64'(bus.PSEL),      64'(0));
        chk("rst_penable",   64'(bus.PENABLE),   64'(0));
        chk("rst_paddr",     64'(bus.PADDR),     64'(0));
        chk("rst_pstrb",     64'(bus.PSTRB),     64'(0));
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
        @(posedge PCLK); #2;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // back-to-back zero-wait reads/writes: 4-cycle turnaround
        rdy_mode = 1;
        @(posedge PCLK); #1;
        send(32'h10, 1'b0, '0, 4'hF, 3'b000, 2'b01, 0, 1'b0, 32'hCAFE0001, 1'b1);
        send(32'h14, 1'b1, 32'h1234_5678, 4'hF, 3'b001, 2'b10, 0, 1'b0, 32'h0, 1'b1);
        chk("turnaround_1", 64'(last_acc - prev_acc), 64'(4));
        send(32'h18, 1'b0, '0, 4'h0, 3'b000, 2'b01, 0, 1'b0, 32'h0BAD_F00D, 1'b1);
        chk("turnaround_2", 64'(last_acc - prev_acc), 64'(4));
        wait_idle();
        rdy_mode = 0;

        // APB4 write with wait states, slave error, timeout, illegal selects
        send(32'h20, 1'b1, 32'hA5A5_A5A5, 4'b0101, 3'b010, 2'b01, 3, 1'b0, 32'h0, 1'b1);
        send(32'h24, 1'b0, '0, 4'h0, 3'b000, 2'b10, 2, 1'b1, 32'h5555_AAAA, 1'b1);
        send(32'h28, 1'b0, '0, 4'h0, 3'b000, 2'b01, TMO, 1'b0, 32'h7777_0000, 1'b1);
        send(32'h2C, 1'b0, '0, 4'h0, 3'b000, 2'b01, TMO + 5, 1'b0, 32'h1111_2222, 1'b1);
        send(32'h30, 1'b1, 32'hFFFF_0000, 4'hF, 3'b000, 2'b00, 0, 1'b0, 32'h0, 1'b1);
        send(32'h34, 1'b0, '0, 4'h0, 3'b000, 2'b11, 0, 1'b0, 32'h0, 1'b1);
        wait_idle();

        // APB3 mode: forced PPROT/PSTRB
        apb4_en = 1'b0;
        send(32'h40, 1'b1, 32'hDEAD_BEEF, 4'b0001, 3'b111, 2'b10, 1, 1'b0, 32'h0, 1'b1);
        send(32'h44, 1'b0, '0, 4'b1111, 3'b111, 2'b10, 0, 1'b0, 32'h3333_4444, 1'b1);
        wait_idle();
        apb4_en = 1'b1;

        // response back-pressure
        rdy_mode = 2;
        @(posedge PCLK); #1;
        send(32'h50, 1'b0, '0, 4'h0, 3'b000, 2'b01, 1, 1'b0, 32'h9999_8888, 1'b1);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 50) begin @(negedge PCLK); n++; end
        chk("bp_rsp_seen", 64'(bus.rsp_valid), 64'(1));
        repeat (5) @(negedge PCLK);
        rdy_mode = 0;
        wait_idle();

        // reset during ACCESS
        completer_off = 1'b1;
        bus.PREADY = 1'b0;
        send(32'h60, 1'b0, '0, 4'h0, 3'b000, 2'b01, 0, 1'b0, 32'h0, 1'b0);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.PENABLE && n < 20) begin @(negedge PCLK); n++; end
        chk("mid_access_seen", 64'(bus.PENABLE), 64'(1));
        #2;
        PRESETn = 1'b0;
        #1;
        chk("mid_rst_psel",      64'(bus.PSEL),      64'(0));
        chk("mid_rst_penable",   64'(bus.PENABLE),   64'(0));
        chk("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
        repeat (2) @(posedge PCLK);
        #2;
        PRESETn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge PCLK);
            chk("post_rst_no_rsp", 64'(bus.rsp_valid), 64'(0));
        end
        completer_off = 1'b0;
        @(posedge PCLK); #1;

        // randomized traffic, APB4 then APB3
        for (int m = 0; m < 2; m++) begin
            apb4_en = (m == 0);
            for (int i = 0; i < 60; i++) begin
                r = $urandom_range(0, 9);
                if (r == 0)      s = 2'b00;
                else if (r == 1) s = 2'b11;
                else if (r < 6)  s = 2'b01;
                else             s = 2'b10;
                wt = ($urandom_range(0, 5) == 0) ? TMO + 1 + $urandom_range(0, 2)
                                                 : $urandom_range(0, 3);
                send($urandom, 1'($urandom), $urandom, 4'($urandom), 3'($urandom), s,
                     wt, 1'($urandom_range(0, 3) == 0), $urandom, 1'b1);
                if ($urandom_range(0, 2) == 0) begin
                    bus.cmd_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) @(posedge PCLK);
                    #1;
                end
            end
            wait_idle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
